// File: rtl/mem_access_unit.sv
// Load/store initiator between the execute stage and a word-indexed, registered-read ram.
// Define MEM_ACCESS_MISALIGN_TRAP_EN to fault misaligned H/HU/SH/W/SW instead of aligning them down.
module mem_access_unit #(
   parameter logic [2:0] REGION_TAG = 3'b000,
   parameter int         WORD_SHIFT = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_fault,
   output logic [31:0] mem_address,
   output logic [31:0] mem_data_in,
   output logic        mem_write_enable,
   input  logic [31:0] mem_data_out
);

   typedef enum logic [2:0] {IDLE, RD, CAP, WR, RESP} state_t;

   state_t      state, state_next;
   logic [31:0] addr_r, data_r;
   logic [2:0]  funct3_r;
   logic        write_r, fault_r;
   logic        accept, fault_req;
   logic [31:0] merged, load_ext;
   logic [7:0]  byte_v;
   logic [15:0] half_v;

   assign accept = req_valid && req_ready;

   always_comb begin
      fault_req = 1'b0;
      if (req_addr[31:29] != REGION_TAG) fault_req = 1'b1;
      case (req_funct3)
         3'b011, 3'b110, 3'b111: fault_req = 1'b1;
         3'b100, 3'b101:         if (req_write) fault_req = 1'b1;
         default:                ;
      endcase
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
      if (req_funct3[1:0] == 2'b01 && req_addr[0])          fault_req = 1'b1;
      if (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00) fault_req = 1'b1;
`endif
   end

   // Lane selection from the registered address; the word index already discards addr[1:0].
   always_comb begin
      byte_v = mem_data_out[{addr_r[1:0], 3'b000} +: 8];
      half_v = mem_data_out[{addr_r[1], 4'b0000} +: 16];
      merged = mem_data_out;
      if (funct3_r[1:0] == 2'b00) merged[{addr_r[1:0], 3'b000} +: 8] = data_r[7:0];
      else                        merged[{addr_r[1], 4'b0000} +: 16] = data_r[15:0];
      case (funct3_r)
         3'b000:  load_ext = {{24{byte_v[7]}}, byte_v};
         3'b001:  load_ext = {{16{half_v[15]}}, half_v};
         3'b100:  load_ext = {24'h0, byte_v};
         3'b101:  load_ext = {16'h0, half_v};
         default: load_ext = mem_data_out;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= IDLE;
         addr_r   <= '0;
         data_r   <= '0;
         funct3_r <= '0;
         write_r  <= 1'b0;
         fault_r  <= 1'b0;
      end else begin
         state <= state_next;
         if (accept) begin
            addr_r   <= req_addr;
            data_r   <= req_wdata;
            funct3_r <= req_funct3;
            write_r  <= req_write;
            fault_r  <= fault_req;
         end else if (state == CAP) begin
            data_r <= write_r ? merged : load_ext;
         end
      end
   end

   // NOTE: every output and next-state value gets a default first so no latch is inferred.
   always_comb begin
      state_next       = state;
      req_ready        = 1'b0;
      resp_valid       = 1'b0;
      resp_fault       = 1'b0;
      resp_rdata       = '0;
      mem_address      = '0;
      mem_data_in      = '0;
      mem_write_enable = 1'b0;
      case (state)
         IDLE: begin
            req_ready = 1'b1;
            if (accept) begin
               if (fault_req)                             state_next = RESP;
               else if (req_write && req_funct3 == 3'b010) state_next = WR;
               else                                       state_next = RD;
            end
         end
         RD: begin
            mem_address = addr_r >> WORD_SHIFT;
            state_next  = CAP;
         end
         CAP: begin
            mem_address = addr_r >> WORD_SHIFT;
            state_next  = write_r ? WR : RESP;
         end
         WR: begin
            mem_address      = addr_r >> WORD_SHIFT;
            mem_data_in      = data_r;
            mem_write_enable = 1'b1;
            state_next       = RESP;
         end
         RESP: begin
            resp_valid = 1'b1;
            resp_fault = fault_r;
            if (!fault_r && !write_r) resp_rdata = data_r;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit with a registered-read word ram model and an
// expected-response queue; latency, write strobes and ram contents are checked per request.
module tb_mem_access_unit;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_write = 1'b0;
   logic [2:0]  req_funct3 = 3'b000;
   logic [31:0] req_addr = '0;
   logic [31:0] req_wdata = '0;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_fault;
   logic [31:0] mem_address;
   logic [31:0] mem_data_in;
   logic        mem_write_enable;
   logic [31:0] mem_data_out;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [31:0] rdata;
      logic        fault;
      int          lat;
      int          we_cnt;
      logic [31:0] wd;
   } exp_t;

   exp_t sb[$];

   logic [31:0] ram [0:255];

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (mem_write_enable) ram[mem_address[7:0]] <= mem_data_in;
      mem_data_out <= ram[mem_address[7:0]];
   end

   mem_access_unit dut (
      .clk              (clk),
      .reset            (reset),
      .req_valid        (req_valid),
      .req_ready        (req_ready),
      .req_write        (req_write),
      .req_funct3       (req_funct3),
      .req_addr         (req_addr),
      .req_wdata        (req_wdata),
      .resp_valid       (resp_valid),
      .resp_rdata       (resp_rdata),
      .resp_fault       (resp_fault),
      .mem_address      (mem_address),
      .mem_data_in      (mem_data_in),
      .mem_write_enable (mem_write_enable),
      .mem_data_out     (mem_data_out)
   );

   task automatic issue(input logic w, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] d, input logic [31:0] er, input logic ef,
                        input int elat, input int ewe, input logic [31:0] ewd,
                        input string nm);
      exp_t e;
      int   cyc;
      int   we_seen;
      bit   got;
      @(negedge clk);
      req_valid  = 1'b1;
      req_write  = w;
      req_funct3 = f;
      req_addr   = a;
      req_wdata  = d;
      e.rdata = er; e.fault = ef; e.lat = elat; e.we_cnt = ewe; e.wd = ewd;
      sb.push_back(e);
      cyc = 0;
      while (!req_ready && cyc < 20) begin
         @(negedge clk);
         cyc++;
      end
      checks++;
      if (req_ready !== 1'b1) begin
         errors++;
         $display("FAIL %s ready: got %b want 1", nm, req_ready);
      end
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      cyc = 1; we_seen = 0; got = 0;
      checks++;
      if (req_ready !== 1'b0) begin
         errors++;
         $display("FAIL %s busy_ready: got %b want 0", nm, req_ready);
      end
      while (!got && cyc <= 8) begin
         if (mem_write_enable === 1'b1) begin
            we_seen++;
            checks++;
            if (mem_address !== (a >> 2) || mem_data_in !== ewd) begin
               errors++;
               $display("FAIL %s wr_bus: got addr %h data %h want addr %h data %h",
                        nm, mem_address, mem_data_in, a >> 2, ewd);
            end
         end
         if (resp_valid === 1'b1) got = 1;
         else begin
            @(posedge clk);
            #1;
            cyc++;
         end
      end
      e = sb.pop_front();
      checks++;
      if (!got) begin
         errors++;
         $display("FAIL %s resp_timeout: no resp_valid within 8 cycles", nm);
      end
      checks++;
      if (cyc != e.lat) begin
         errors++;
         $display("FAIL %s latency: got %0d want %0d", nm, cyc, e.lat);
      end
      checks++;
      if (resp_rdata !== e.rdata || resp_fault !== e.fault) begin
         errors++;
         $display("FAIL %s resp: got rdata %h fault %b want rdata %h fault %b",
                  nm, resp_rdata, resp_fault, e.rdata, e.fault);
      end
      checks++;
      if (we_seen != e.we_cnt) begin
         errors++;
         $display("FAIL %s we_cycles: got %0d want %0d", nm, we_seen, e.we_cnt);
      end
      @(posedge clk);
      #1;
      checks++;
      if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
         errors++;
         $display("FAIL %s after_resp: got valid %b ready %b want 0 1", nm, resp_valid, req_ready);
      end
   endtask

   task automatic test_reset;
      reset = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if ({resp_valid, resp_fault, mem_write_enable} !== 3'b000 || resp_rdata !== 32'h0 ||
          mem_address !== 32'h0 || mem_data_in !== 32'h0) begin
         errors++;
         $display("FAIL reset_outputs: got v%b f%b we%b rdata %h addr %h din %h want all 0",
                  resp_valid, resp_fault, mem_write_enable, resp_rdata, mem_address, mem_data_in);
      end
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
      checks++;
      if (req_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_ready: got %b want 1", req_ready);
      end
   endtask

   task automatic test_word;
      issue(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 2, 1, 32'hDEADBEEF, "sw_10");
      issue(1'b0, 3'b010, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 3, 0, 32'h0, "lw_10");
   endtask

   task automatic test_byte_half;
      issue(1'b1, 3'b000, 32'h13, 32'h000000AA, 32'h0, 1'b0, 4, 1, 32'hAAADBEEF, "sb_13");
      issue(1'b0, 3'b000, 32'h13, 32'h0, 32'hFFFFFFAA, 1'b0, 3, 0, 32'h0, "lb_13");
      issue(1'b0, 3'b100, 32'h13, 32'h0, 32'h000000AA, 1'b0, 3, 0, 32'h0, "lbu_13");
      issue(1'b1, 3'b001, 32'h12, 32'h00001234, 32'h0, 1'b0, 4, 1, 32'h1234BEEF, "sh_12");
      issue(1'b0, 3'b001, 32'h12, 32'h0, 32'h00001234, 1'b0, 3, 0, 32'h0, "lh_12");
      issue(1'b0, 3'b001, 32'h10, 32'h0, 32'hFFFFBEEF, 1'b0, 3, 0, 32'h0, "lh_10");
      issue(1'b0, 3'b101, 32'h10, 32'h0, 32'h0000BEEF, 1'b0, 3, 0, 32'h0, "lhu_10");
      issue(1'b0, 3'b000, 32'h10, 32'h0, 32'hFFFFFFEF, 1'b0, 3, 0, 32'h0, "lb_10");
      issue(1'b0, 3'b100, 32'h11, 32'h0, 32'h000000BE, 1'b0, 3, 0, 32'h0, "lbu_11");
      issue(1'b0, 3'b000, 32'h12, 32'h0, 32'h00000034, 1'b0, 3, 0, 32'h0, "lb_12");
   endtask

   task automatic test_misalign;
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
      issue(1'b0, 3'b010, 32'h11, 32'h0, 32'h0, 1'b1, 1, 0, 32'h0, "lw_11");
      issue(1'b1, 3'b001, 32'h11, 32'h5678, 32'h0, 1'b1, 1, 0, 32'h0, "sh_11");
      issue(1'b0, 3'b010, 32'h10, 32'h0, 32'h1234BEEF, 1'b0, 3, 0, 32'h0, "lw_10_after");
`else
      issue(1'b0, 3'b010, 32'h11, 32'h0, 32'h1234BEEF, 1'b0, 3, 0, 32'h0, "lw_11");
      issue(1'b1, 3'b001, 32'h11, 32'h5678, 32'h0, 1'b0, 4, 1, 32'h12345678, "sh_11");
      issue(1'b0, 3'b010, 32'h10, 32'h0, 32'h12345678, 1'b0, 3, 0, 32'h0, "lw_10_after");
`endif
   endtask

   task automatic test_faults;
      issue(1'b1, 3'b010, 32'h0, 32'hCAFEF00D, 32'h0, 1'b0, 2, 1, 32'hCAFEF00D, "sw_0");
      issue(1'b1, 3'b010, 32'h20000000, 32'h0, 32'h0, 1'b1, 1, 0, 32'h0, "sw_region");
      issue(1'b0, 3'b011, 32'h0, 32'h0, 32'h0, 1'b1, 1, 0, 32'h0, "ld_f011");
      issue(1'b1, 3'b011, 32'h0, 32'h0, 32'h0, 1'b1, 1, 0, 32'h0, "st_f011");
      issue(1'b1, 3'b100, 32'h0, 32'h0, 32'h0, 1'b1, 1, 0, 32'h0, "st_f100");
      issue(1'b0, 3'b111, 32'h0, 32'h0, 32'h0, 1'b1, 1, 0, 32'h0, "ld_f111");
      issue(1'b0, 3'b010, 32'hE0000000, 32'h0, 32'h0, 1'b1, 1, 0, 32'h0, "lw_region");
      issue(1'b0, 3'b010, 32'h0, 32'h0, 32'hCAFEF00D, 1'b0, 3, 0, 32'h0, "lw_0_kept");
   endtask

   task automatic test_back_to_back;
      for (int i = 0; i < 4; i++) begin
         logic [31:0] a;
         logic [31:0] d;
         a = 32'h80 + 32'(i * 4);
         d = $urandom;
         issue(1'b1, 3'b010, a, d, 32'h0, 1'b0, 2, 1, d, "b2b_sw");
         issue(1'b0, 3'b010, a, 32'h0, d, 1'b0, 3, 0, 32'h0, "b2b_lw");
      end
   endtask

   task automatic test_reset_during_store;
      issue(1'b1, 3'b010, 32'h40, 32'h11223344, 32'h0, 1'b0, 2, 1, 32'h11223344, "sw_40");
      @(negedge clk);
      req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'b000;
      req_addr = 32'h43; req_wdata = 32'h55;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (mem_write_enable !== 1'b1) begin
         errors++;
         $display("FAIL rst_wr_state: got we %b want 1", mem_write_enable);
      end
      @(negedge clk);
      reset = 1'b0;
      #1;
      checks++;
      if (mem_write_enable !== 1'b0 || resp_valid !== 1'b0) begin
         errors++;
         $display("FAIL rst_we_drop: got we %b valid %b want 0 0", mem_write_enable, resp_valid);
      end
      @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      #1;
      checks++;
      if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
         errors++;
         $display("FAIL rst_release: got ready %b valid %b want 1 0", req_ready, resp_valid);
      end
      @(posedge clk);
      #1;
      checks++;
      if (resp_valid !== 1'b0) begin
         errors++;
         $display("FAIL rst_no_resp: got valid %b want 0", resp_valid);
      end
      issue(1'b0, 3'b010, 32'h40, 32'h0, 32'h11223344, 1'b0, 3, 0, 32'h0, "lw_40_kept");
   endtask

   initial begin
      test_reset();
      test_word();
      test_byte_half();
      test_misalign();
      test_faults();
      test_back_to_back();
      test_reset_during_store();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
